// File: rtl/alu_pack_seq.sv
// Registered add/sub/and/shift-add multiply ALU with valid/ready ports.
// Optional zero/carry flag outputs are enabled by defining ALU_FLAGS_EN.
module alu_pack_seq #(
    parameter int WIDTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cin,
    input  logic [1:0]         select,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out,
`ifdef ALU_FLAGS_EN
    output logic               zero,
    output logic               carry,
`endif
    output logic               busy
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CW-1:0]    cnt;
    logic [RW-1:0]    acc;
    logic [RW-1:0]    out_r;

    logic             accept;
    logic             mul_last;
    logic [RW-1:0]    add_res;
    logic [RW-1:0]    sub_res;
    logic [RW-1:0]    and_res;
    logic [RW-1:0]    quick_res;
    logic [WIDTH-1:0] b_sh;
    logic [RW-1:0]    partial;

    assign accept   = in_valid && (state == IDLE);
    assign mul_last = (cnt == CW'(WIDTH));
    assign out      = out_r;

    // Single-cycle results computed straight from the port operands
    always_comb begin
        add_res   = RW'(a) + RW'(b) + RW'(cin);
        sub_res   = RW'(a) - RW'(b) - RW'(cin);
        and_res   = RW'(a & b);
        quick_res = '0;
        unique case (select)
            2'b00:   quick_res = add_res;
            2'b01:   quick_res = sub_res;
            2'b10:   quick_res = and_res;
            default: quick_res = '0;
        endcase
    end

    // Shift-add partial product for the current multiplier bit
    always_comb begin
        b_sh    = b_reg >> cnt;
        partial = '0;
        if (b_sh[0]) begin
            partial = RW'(a_reg) << cnt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = (select == 2'b11) ? MUL : DONE;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (mul_last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register, operand capture, multiplier datapath and result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            cnt   <= '0;
            acc   <= '0;
            out_r <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_reg <= a;
                b_reg <= b;
                cnt   <= '0;
                acc   <= '0;
                if (select != 2'b11) begin
                    out_r <= quick_res;
                end
            end else if (state == MUL) begin
                if (mul_last) begin
                    out_r <= acc;
                end else begin
                    acc <= acc + partial;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

`ifdef ALU_FLAGS_EN
    logic         zero_r;
    logic         carry_r;
    logic         add_c;
    logic         sub_b;
    logic [WIDTH:0] b_cin;

    assign add_c = add_res[WIDTH];
    assign b_cin = {1'b0, b} + (WIDTH + 1)'(cin);
    assign sub_b = ({1'b0, a} < b_cin);
    assign zero  = zero_r;
    assign carry = carry_r;

    // Flags are registered alongside the result they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_r  <= 1'b0;
            carry_r <= 1'b0;
        end else if (accept && (select != 2'b11)) begin
            zero_r  <= (quick_res == '0);
            carry_r <= (select == 2'b00) ? add_c :
                       (select == 2'b01) ? sub_b : 1'b0;
        end else if ((state == MUL) && mul_last) begin
            zero_r  <= (acc == '0);
            carry_r <= 1'b0;
        end
    end
`endif

endmodule
